// File: rtl/magnetron_pkg.sv
// Shared definitions for the magnetron power controller.
// Holds the FSM state width and state encodings used by the top level and
// visible to anything that decodes o_state.
package magnetron_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_COOK  = 2'd1;
  localparam logic [STATE_W-1:0] ST_PAUSE = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/magnetron_pwm.sv
// Duty-cycle generator for the magnetron.
// Keeps the window counter, the latched (clamped) power level and the
// registered on term. The window is LEVELS*SLOT cycles long; the output is on
// for the first lvl*SLOT cycles of each window.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_cook_now        FSM is currently in COOK
//   i_cook_next       FSM will be in COOK after this edge
//   i_power_level     requested level, 0..LEVELS (larger values clamp)
//   o_on_q            registered duty term
module magnetron_pwm
  import magnetron_pkg::*;
#(
  parameter int LEVELS = 10,
  parameter int SLOT   = 100,
  localparam int LW    = $clog2(LEVELS + 1),
  localparam int CNT_W = $clog2(LEVELS * SLOT + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cook_now,
  input  logic          i_cook_next,
  input  logic [LW-1:0] i_power_level,
  output logic          o_on_q
);

  localparam logic [LW-1:0]    LVL_MAX  = LW'(LEVELS);
  localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(LEVELS * SLOT - 1);

  logic [CNT_W-1:0] r_win_cnt;
  logic [LW-1:0]    r_lvl;
  logic             r_on_q;

  logic             w_enter;
  logic             w_stay;
  logic             w_wrap;
  logic [LW-1:0]    w_lvl_clamped;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [LW-1:0]    w_lvl_nxt;
  logic [CNT_W-1:0] w_thr_nxt;

  assign w_enter       = i_cook_next & ~i_cook_now;
  assign w_stay        = i_cook_next & i_cook_now;
  assign w_wrap        = (r_win_cnt == WIN_LAST);
  assign w_lvl_clamped = (i_power_level > LVL_MAX) ? LVL_MAX : i_power_level;

  always_comb begin
    w_cnt_nxt = r_win_cnt;
    w_lvl_nxt = r_lvl;
    if (w_enter) begin
      w_cnt_nxt = '0;
      w_lvl_nxt = w_lvl_clamped;
    end else if (w_stay) begin
      if (w_wrap) begin
        w_cnt_nxt = '0;
        w_lvl_nxt = w_lvl_clamped;
      end else begin
        w_cnt_nxt = r_win_cnt + 1'b1;
      end
    end
  end

  // lvl never exceeds LEVELS, so the product always fits in CNT_W bits.
  assign w_thr_nxt = CNT_W'(w_lvl_nxt) * SLOT_C;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_win_cnt <= '0;
      r_lvl     <= '0;
      r_on_q    <= 1'b0;
    end else begin
      r_win_cnt <= w_cnt_nxt;
      r_lvl     <= w_lvl_nxt;
      r_on_q    <= i_cook_next & (w_cnt_nxt < w_thr_nxt);
    end
  end

  assign o_on_q = r_on_q;

endmodule

// File: rtl/magnetron_power_ctrl.sv
// Magnetron power controller: start/stop/cancel FSM plus duty-cycle power
// control with a combinational door interlock on the magnetron enable.
//
// state | meaning
// IDLE  | waiting for a valid start
// COOK  | cooking, magnetron duty-cycled by the power level
// PAUSE | stopped or door opened, waiting for restart or cancel
// DONE  | timer expired, one-cycle completion pulse
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_startn/i_stopn/i_clearn  active-low start, stop, cancel
//   i_door_closed        1 = door closed
//   i_timer_done         cook timer expired (level)
//   i_power_level        requested level 0..LEVELS
//   o_mag_on             magnetron enable
//   o_state              FSM state code
//   o_done               completion pulse
module magnetron_power_ctrl
  import magnetron_pkg::*;
#(
  parameter int LEVELS = 10,
  parameter int SLOT   = 100,
  localparam int LW    = $clog2(LEVELS + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_startn,
  input  logic               i_stopn,
  input  logic               i_clearn,
  input  logic               i_door_closed,
  input  logic               i_timer_done,
  input  logic [LW-1:0]      i_power_level,
  output logic               o_mag_on,
  output logic [STATE_W-1:0] o_state,
  output logic               o_done
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic               w_start_ok;
  logic               w_on_q;

  assign w_start_ok = ~i_startn & i_door_closed & i_stopn & i_clearn & ~i_timer_done;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_nxt = ST_COOK;
      ST_COOK: begin
        if (!i_clearn)                        w_state_nxt = ST_IDLE;
        else if (i_timer_done)                w_state_nxt = ST_DONE;
        else if (!i_stopn || !i_door_closed)  w_state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (!i_clearn)       w_state_nxt = ST_IDLE;
        else if (w_start_ok) w_state_nxt = ST_COOK;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  magnetron_pwm #(
    .LEVELS(LEVELS),
    .SLOT  (SLOT)
  ) u_pwm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cook_now   (r_state == ST_COOK),
    .i_cook_next  (w_state_nxt == ST_COOK),
    .i_power_level(i_power_level),
    .o_on_q       (w_on_q)
  );

  // Door interlock is deliberately combinational so opening the door cuts
  // the magnetron without waiting for a clock edge.
  assign o_mag_on = w_on_q & i_door_closed;
  assign o_state  = r_state;
  assign o_done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_magnetron_power_ctrl.sv
module tb_magnetron_power_ctrl;

  localparam int LEVELS = 10;
  localparam int SLOT   = 4;
  localparam int WIN    = LEVELS * SLOT;

  logic       clk = 1'b0;
  logic       rst, startn, stopn, clearn, door_closed, timer_done;
  logic [3:0] power_level;
  logic       mag_on, done;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  magnetron_power_ctrl #(.LEVELS(LEVELS), .SLOT(SLOT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_startn     (startn),
    .i_stopn      (stopn),
    .i_clearn     (clearn),
    .i_door_closed(door_closed),
    .i_timer_done (timer_done),
    .i_power_level(power_level),
    .o_mag_on     (mag_on),
    .o_state      (state),
    .o_done       (done)
  );

  typedef struct {
    logic       rst, startn, stopn, clearn, door, tdone;
    logic [3:0] pl;
    logic [1:0] e_state;
    logic       e_mag, e_done;
  } vec_t;

  vec_t tbl[21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [1:0] es, input logic em, input logic ed);
    n_vec++;
    if (state !== es || mag_on !== em || done !== ed) begin
      n_err++;
      $display("FAIL %s: got state=%0d mag_on=%0b done=%0b, required state=%0d mag_on=%0b done=%0b",
               nm, state, mag_on, done, es, em, ed);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; startn = 1; stopn = 1; clearn = 1; door_closed = 1; timer_done = 0;
  endtask

  // Start cooking from IDLE at level pl, optionally switching to pl2 after
  // cook cycle chg_at, and check the duty pattern for n cycles.
  task automatic run_pattern(input string nm, input int pl, input int pl2,
                             input int chg_at, input int n);
    int cur_pl;
    int lvl_m;
    logic em;
    idle_inputs();
    power_level = 4'(pl);
    cur_pl = pl;
    startn = 0;
    tick();
    startn = 1;
    lvl_m = 0;
    for (int i = 0; i < n; i++) begin
      if (i % WIN == 0) lvl_m = (cur_pl > LEVELS) ? LEVELS : cur_pl;
      em = ((i % WIN) < lvl_m * SLOT);
      chk($sformatf("%s_c%0d", nm, i), 2'd1, em, 1'b0);
      if (i == chg_at) begin
        power_level = 4'(pl2);
        cur_pl = pl2;
      end
      tick();
    end
    clearn = 0;
    tick();
    chk({nm, "_clear"}, 2'd0, 1'b0, 1'b0);
    clearn = 1;
  endtask

  initial begin
    //            rst st sp cl dr td pl   state mag done
    tbl[0]  = '{1, 0, 1, 1, 1, 0, 5,  0, 0, 0};
    tbl[1]  = '{1, 0, 1, 1, 1, 0, 5,  0, 0, 0};
    tbl[2]  = '{0, 1, 1, 1, 1, 0, 5,  0, 0, 0};
    tbl[3]  = '{0, 0, 1, 1, 0, 0, 5,  0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 1, 0, 5,  0, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 1, 0, 5,  0, 0, 0};
    tbl[6]  = '{0, 0, 1, 1, 1, 1, 5,  0, 0, 0};
    tbl[7]  = '{0, 0, 1, 1, 1, 0, 5,  1, 1, 0};
    tbl[8]  = '{0, 1, 1, 1, 1, 0, 5,  1, 1, 0};
    tbl[9]  = '{0, 1, 0, 1, 1, 0, 5,  2, 0, 0};
    tbl[10] = '{0, 0, 1, 1, 1, 0, 5,  1, 1, 0};
    tbl[11] = '{0, 1, 1, 0, 1, 1, 5,  0, 0, 0};
    tbl[12] = '{0, 0, 1, 1, 1, 0, 5,  1, 1, 0};
    tbl[13] = '{0, 1, 1, 1, 1, 1, 5,  3, 0, 1};
    tbl[14] = '{0, 1, 1, 1, 1, 0, 5,  0, 0, 0};
    tbl[15] = '{0, 0, 1, 1, 1, 0, 0,  1, 0, 0};
    tbl[16] = '{0, 1, 1, 1, 1, 0, 0,  1, 0, 0};
    tbl[17] = '{0, 1, 1, 0, 1, 0, 15, 0, 0, 0};
    tbl[18] = '{0, 0, 1, 1, 1, 0, 15, 1, 1, 0};
    tbl[19] = '{1, 1, 1, 1, 1, 0, 15, 0, 0, 0};
    tbl[20] = '{0, 1, 1, 1, 1, 0, 15, 0, 0, 0};

    idle_inputs();
    power_level = 0;
    #2;
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst; startn = tbl[i].startn; stopn = tbl[i].stopn;
      clearn = tbl[i].clearn; door_closed = tbl[i].door;
      timer_done = tbl[i].tdone; power_level = tbl[i].pl;
      tick();
      chk($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_mag, tbl[i].e_done);
    end

    // 50% duty over two windows
    run_pattern("lvl5", 5, 5, -1, 2 * WIN);
    // zero level never fires, over-range level clamps to full-on
    run_pattern("lvl0", 0, 0, -1, WIN + 5);
    run_pattern("lvl15", 15, 15, -1, WIN + 5);
    // level change mid-window takes effect only at the wrap
    run_pattern("chg5to2", 5, 2, 10, 2 * WIN);

    // Door opened at cook cycle 7, then restart from PAUSE
    idle_inputs();
    power_level = 5;
    startn = 0;
    tick();
    startn = 1;
    for (int i = 0; i < 7; i++) tick();
    chk("door_pre", 2'd1, 1'b1, 1'b0);
    door_closed = 0;
    #1;
    chk("door_open_comb", 2'd1, 1'b0, 1'b0);
    tick();
    chk("door_pause", 2'd2, 1'b0, 1'b0);
    door_closed = 1;
    startn = 0;
    tick();
    startn = 1;
    // If the counter resumed at 7 instead of 0, mag_on would drop 7 cycles early.
    for (int i = 0; i <= 20; i++) begin
      chk($sformatf("door_restart_c%0d", i), 2'd1, (i < 20), 1'b0);
      tick();
    end

    // Reset mid-cook while still requesting start
    rst = 1;
    startn = 0;
    tick();
    chk("rst_midcook", 2'd0, 1'b0, 1'b0);
    tick();
    chk("rst_hold", 2'd0, 1'b0, 1'b0);
    rst = 0;
    startn = 1;
    tick();
    chk("rst_release", 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
